// File: rtl/a2d_sched.sv
// a2d_sched: sampling scheduler for the SPI A2D interface.
//
// Issues a one-cycle `nxt` start pulse every PERIOD clocks while `en` is high.
// Each conversion is two SPI transactions; completion is the second rising
// edge of `SS_n` after `nxt`. A stalled conversion (no `SS_n` rise within
// TIMEOUT clocks) parks the block in a terminal fault state until reset.
//
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   en        level, enables periodic sampling
//   SS_n      slave select from the SPI master (same clock domain)
//   nxt       one-cycle start pulse to the A2D interface
//   chan_idx  channel the next conversion will read (mirrors the interface counter)
//   smpl_vld  one-cycle pulse, conversion for smpl_ch complete
//   smpl_ch   channel just completed, valid with smpl_vld
//   all_vld   every channel converted at least once since reset
//   timeout   sticky stall fault flag
//   busy      conversion in flight (ISSUE, WAIT1, WAIT2)

module a2d_sched #(
  parameter int unsigned PERIOD  = 1024,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       SS_n,
  output logic       nxt,
  output logic [1:0] chan_idx,
  output logic       smpl_vld,
  output logic [1:0] smpl_ch,
  output logic       all_vld,
  output logic       timeout,
  output logic       busy
);

  localparam logic [15:0] PerLast = 16'(PERIOD - 1);
  localparam logic [15:0] ToLast  = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait1,
    StWait2,
    StHold,
    StFault
  } state_e;

  state_e      state_q, state_d;
  logic        ss_q;
  logic        ss_rise;
  logic [15:0] per_cnt_q, per_cnt_d;
  logic [15:0] to_cnt_q, to_cnt_d;
  logic [1:0]  chan_q, chan_d;
  logic [1:0]  smpl_ch_q, smpl_ch_d;
  logic [3:0]  seen_q, seen_d;
  logic        smpl_vld_q, smpl_vld_d;
  logic        all_vld_q, all_vld_d;
  logic        timeout_q, timeout_d;
  logic        conv_done;

  assign ss_rise = SS_n & ~ss_q;

  // Next-state logic. Counters are "cleared" by loading 1: the cycle in which
  // the clear happens is itself count 0, so PERIOD/TIMEOUT are measured exactly
  // from the ISSUE cycle (or from the ss_rise cycle for the timeout counter).
  always_comb begin
    state_d   = state_q;
    per_cnt_d = (per_cnt_q == PerLast) ? per_cnt_q : per_cnt_q + 16'd1;
    to_cnt_d  = to_cnt_q;
    timeout_d = timeout_q;
    conv_done = 1'b0;

    case (state_q)
      StIdle: begin
        if (en) state_d = StIssue;
      end
      StIssue: begin
        per_cnt_d = 16'd1;
        to_cnt_d  = 16'd1;
        state_d   = StWait1;
      end
      StWait1: begin
        // A rise in the expiry cycle wins over the timeout.
        if (ss_rise) begin
          state_d  = StWait2;
          to_cnt_d = 16'd1;
        end else if (to_cnt_q == ToLast) begin
          state_d   = StFault;
          timeout_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 16'd1;
        end
      end
      StWait2: begin
        if (ss_rise) begin
          state_d   = StHold;
          conv_done = 1'b1;
        end else if (to_cnt_q == ToLast) begin
          state_d   = StFault;
          timeout_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 16'd1;
        end
      end
      StHold: begin
        // Counter saturates, so a late completion gets a single HOLD cycle.
        if (!en) begin
          state_d = StIdle;
        end else if (per_cnt_q == PerLast) begin
          state_d = StIssue;
        end
      end
      StFault: begin
        state_d = StFault;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Completion bookkeeping, effective the cycle after the final ss_rise.
  always_comb begin
    smpl_vld_d = conv_done;
    smpl_ch_d  = conv_done ? chan_q : smpl_ch_q;
    chan_d     = conv_done ? chan_q + 2'd1 : chan_q;
    seen_d     = conv_done ? (seen_q | (4'b0001 << chan_q)) : seen_q;
    all_vld_d  = &seen_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      ss_q       <= 1'b1;
      per_cnt_q  <= 16'd0;
      to_cnt_q   <= 16'd0;
      chan_q     <= 2'd0;
      smpl_ch_q  <= 2'd0;
      seen_q     <= 4'd0;
      smpl_vld_q <= 1'b0;
      all_vld_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ss_q       <= SS_n;
      per_cnt_q  <= per_cnt_d;
      to_cnt_q   <= to_cnt_d;
      chan_q     <= chan_d;
      smpl_ch_q  <= smpl_ch_d;
      seen_q     <= seen_d;
      smpl_vld_q <= smpl_vld_d;
      all_vld_q  <= all_vld_d;
      timeout_q  <= timeout_d;
    end
  end

  assign nxt      = (state_q == StIssue);
  assign busy     = (state_q == StIssue) || (state_q == StWait1) || (state_q == StWait2);
  assign chan_idx = chan_q;
  assign smpl_vld = smpl_vld_q;
  assign smpl_ch  = smpl_ch_q;
  assign all_vld  = all_vld_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_a2d_sched.sv
// Bench for a2d_sched: SPI master model driving SS_n, scoreboard of expected
// channels pushed on nxt and popped on smpl_vld.

module tb_a2d_sched;

  localparam int Period  = 64;
  localparam int Timeout = 256;
  localparam int Gap     = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       SS_n;
  logic       nxt;
  logic [1:0] chan_idx;
  logic       smpl_vld;
  logic [1:0] smpl_ch;
  logic       all_vld;
  logic       timeout;
  logic       busy;

  a2d_sched #(
    .PERIOD (Period),
    .TIMEOUT(Timeout)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .SS_n    (SS_n),
    .nxt     (nxt),
    .chan_idx(chan_idx),
    .smpl_vld(smpl_vld),
    .smpl_ch (smpl_ch),
    .all_vld (all_vld),
    .timeout (timeout),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // SPI master model: two transactions per nxt, lengths len1/len2 cycles low,
  // Gap cycles high between them. stall drops the second transaction; spur
  // toggles SS_n while the model is idle.
  int spi_ph, spi_cnt, len1, len2, rise1_cyc;
  bit stall, spur;

  initial begin : spi_model
    SS_n    = 1'b1;
    spi_ph  = 0;
    spi_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        spi_ph = 0;
        SS_n   = 1'b1;
      end else begin
        case (spi_ph)
          0: begin
            if (nxt) begin
              spi_ph  = 1;
              spi_cnt = 0;
              SS_n    = 1'b0;
            end else if (spur) begin
              SS_n = ~SS_n;
            end
          end
          1: begin
            spi_cnt++;
            if (spi_cnt >= len1) begin
              SS_n      = 1'b1;
              rise1_cyc = cyc;
              spi_ph    = 2;
              spi_cnt   = 0;
            end
          end
          2: begin
            spi_cnt++;
            if (spi_cnt >= Gap) begin
              if (stall) begin
                spi_ph = 0;
              end else begin
                SS_n    = 1'b0;
                spi_ph  = 3;
                spi_cnt = 0;
              end
            end
          end
          3: begin
            spi_cnt++;
            if (spi_cnt >= len2) begin
              SS_n   = 1'b1;
              spi_ph = 0;
            end
          end
          default: spi_ph = 0;
        endcase
      end
    end
  end

  // Monitor / scoreboard, sampling on the falling edge.
  logic [1:0] sb[$];
  int         nxt_times[$];
  int         vld_times[$];
  logic [1:0] exp_ch;
  logic [3:0] exp_seen;
  logic [1:0] e;
  bit         chk_all, prev_busy, prev_vld, to_seen;
  int         prev_ph, to_time;

  initial begin : monitor
    exp_ch = 2'd0; exp_seen = 4'd0; chk_all = 0; prev_busy = 0; prev_vld = 0;
    to_seen = 0; prev_ph = 0; to_time = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
        exp_ch    = 2'd0;
        exp_seen  = 4'd0;
        chk_all   = 0;
        prev_busy = 0;
        prev_vld  = 0;
        prev_ph   = 0;
        to_seen   = 0;
      end else begin
        if (chk_all) begin
          check_eq("all_vld_next", 32'(all_vld), 32'(&exp_seen));
          chk_all = 0;
        end
        if (nxt) begin
          check_eq("nxt_chan", 32'(chan_idx), 32'(exp_ch));
          check_eq("nxt_after_busy", 32'(prev_busy), 0);
          check_eq("nxt_overlap", prev_ph, 0);
          sb.push_back(exp_ch);
          exp_ch = exp_ch + 2'd1;
          nxt_times.push_back(cyc);
        end
        if (smpl_vld) begin
          check_eq("vld_pulse", 32'(prev_vld), 0);
          check_eq("vld_pending", 32'(sb.size() > 0), 1);
          check_eq("all_vld_at_vld", 32'(all_vld), 32'(&exp_seen));
          if (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq("smpl_ch", 32'(smpl_ch), 32'(e));
            exp_seen[e] = 1'b1;
            chk_all = 1;
          end
          vld_times.push_back(cyc);
        end
        if (timeout && !to_seen) begin
          to_seen = 1;
          to_time = cyc;
        end
        prev_busy = busy;
        prev_vld  = smpl_vld;
        prev_ph   = spi_ph;
      end
    end
  end

  task automatic clear_logs();
    nxt_times.delete();
    vld_times.delete();
  endtask

  task automatic wait_vld(input int n);
    int budget = 2000;
    while (vld_times.size() < n && budget > 0) begin
      tick();
      budget--;
    end
    if (budget == 0) check_eq("wait_vld", vld_times.size(), n);
  endtask

  task automatic wait_ph(input int p);
    int budget = 500;
    while (spi_ph != p && budget > 0) begin
      tick();
      budget--;
    end
    if (budget == 0) check_eq("wait_spi_phase", spi_ph, p);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_nxt"},      32'(nxt), 0);
    check_eq({tag, "_chan_idx"}, 32'(chan_idx), 0);
    check_eq({tag, "_smpl_vld"}, 32'(smpl_vld), 0);
    check_eq({tag, "_smpl_ch"},  32'(smpl_ch), 0);
    check_eq({tag, "_all_vld"},  32'(all_vld), 0);
    check_eq({tag, "_timeout"},  32'(timeout), 0);
    check_eq({tag, "_busy"},     32'(busy), 0);
  endtask

  int t0, k, nc, budget;

  initial begin : main
    rst_n = 1'b0; en = 1'b0; len1 = 18; len2 = 18; stall = 0; spur = 0; rise1_cyc = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    tick();
    rst_n = 1'b1;

    // Steady state: nxt every Period clocks, channels 0..3,0.
    tick();
    clear_logs();
    en = 1'b1;
    t0 = cyc;
    wait_vld(5);
    if (nxt_times.size() >= 5 && vld_times.size() >= 1) begin
      check_eq("en_to_nxt", nxt_times[0], t0 + 1);
      for (int i = 0; i < 4; i++) check_eq("nxt_period", nxt_times[i+1] - nxt_times[i], Period);
      check_eq("conv_len", vld_times[0] - nxt_times[0], 18 + Gap + 18 + 1);
    end
    check_eq("all_vld_set", 32'(all_vld), 1);

    // Conversion longer than Period: back-to-back with a single HOLD cycle.
    len1 = 40; len2 = 40;
    clear_logs();
    wait_vld(3);
    if (nxt_times.size() >= 3 && vld_times.size() >= 3) begin
      check_eq("long_conv_len", vld_times[0] - nxt_times[0], 40 + Gap + 40 + 1);
      check_eq("long_hold0", nxt_times[1] - vld_times[0], 1);
      check_eq("long_hold1", nxt_times[2] - vld_times[1], 1);
    end

    // en dropped during the second transaction.
    len1 = 18; len2 = 18;
    wait_ph(3);
    en = 1'b0;
    k  = vld_times.size();
    nc = nxt_times.size();
    wait_vld(k + 1);
    repeat (150) tick();
    check_eq("one_vld_after_drop", vld_times.size(), k + 1);
    check_eq("no_nxt_en_low", nxt_times.size(), nc);
    check_eq("busy_en_low", 32'(busy), 0);
    check_eq("chan_after_drop", 32'(chan_idx), 32'(exp_ch));

    // Re-enable with spurious SS_n toggles while the SPI model is idle.
    spur = 1;
    clear_logs();
    en = 1'b1;
    wait_vld(3);
    check_eq("spur_no_extra_vld", vld_times.size(), nxt_times.size());
    spur = 0;

    // First transaction rises exactly in the timeout expiry cycle.
    len1 = Timeout - 1;
    clear_logs();
    wait_vld(1);
    len1 = 18;
    check_eq("coincident_no_fault", 32'(timeout), 0);
    if (nxt_times.size() >= 1 && vld_times.size() >= 1)
      check_eq("coincident_len", vld_times[0] - nxt_times[0], (Timeout - 1) + Gap + 18 + 1);

    // Asynchronous reset during WAIT1.
    wait_ph(1);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    en = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    clear_logs();
    en = 1'b1;
    t0 = cyc;
    wait_vld(1);
    if (nxt_times.size() >= 1) check_eq("en_to_nxt_rst", nxt_times[0], t0 + 1);

    // Stall after the first transaction: fault exactly Timeout clocks later.
    stall = 1;
    budget = 1000;
    while (!to_seen && budget > 0) begin
      tick();
      budget--;
    end
    check_eq("timeout_seen", 32'(to_seen), 1);
    check_eq("stall_timeout_time", to_time - rise1_cyc, Timeout);
    nc = nxt_times.size();
    repeat (200) tick();
    check_eq("no_nxt_fault", nxt_times.size(), nc);
    check_eq("timeout_sticky", 32'(timeout), 1);
    check_eq("busy_fault", 32'(busy), 0);

    // Reset clears the fault; sequence restarts at channel 0.
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("rst_clr_timeout", 32'(timeout), 0);
    stall = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    clear_logs();
    wait_vld(2);
    check_eq("timeout_after_rst", 32'(timeout), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
